// File: rtl/pulse_gen_multi_core.sv
// Multi-channel pulse generator on an 8-bit register bus. Each channel counts
// out DELAY then WIDTH cycles, REPEAT times, started by software, EXT_START or a chain.
module pulse_gen_multi_core #(
    parameter int ABUSWIDTH = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 EXT_START,
    output logic [CHANNELS-1:0]  PULSE,
    output logic [CHANNELS-1:0]  FINISH
);
    localparam int         NBYTES  = CNT_WIDTH / 8;
    localparam int         PW      = CNT_WIDTH + 1;
    localparam logic [7:0] VERSION = 8'd2;

    localparam logic [ABUSWIDTH-1:0] A_CTRL   = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] A_START  = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] A_STOP   = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] A_EXT_EN = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] A_CHAIN  = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] A_INV    = ABUSWIDTH'(5);
    localparam logic [ABUSWIDTH-1:0] BLK_BASE = ABUSWIDTH'(16);
    localparam logic [ABUSWIDTH-1:0] BLK_END  = ABUSWIDTH'(16 + 16 * CHANNELS);

    // Global configuration
    logic [CHANNELS-1:0]  ext_en_q, ext_en_d;
    logic [CHANNELS-1:0]  chain_q, chain_d;
    logic [CHANNELS-1:0]  inv_q, inv_d;

    // Per-channel configuration and run state
    logic [CNT_WIDTH-1:0] delay_q [CHANNELS];
    logic [CNT_WIDTH-1:0] delay_d [CHANNELS];
    logic [CNT_WIDTH-1:0] width_q [CHANNELS];
    logic [CNT_WIDTH-1:0] width_d [CHANNELS];
    logic [CNT_WIDTH-1:0] rpt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] rpt_d   [CHANNELS];
    logic [PW-1:0]        cnt_q   [CHANNELS];
    logic [PW-1:0]        cnt_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] rep_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] rep_d   [CHANNELS];
    logic [PW-1:0]        per_w   [CHANNELS];

    logic [CHANNELS-1:0]  pulse_q, pulse_d;
    logic [CHANNELS-1:0]  fin_w;
    logic [CHANNELS-1:0]  done_w;
    logic [7:0]           rdata_q, rdata_d;
    logic [7:0]           rd_val;

    logic ext_meta_q, ext_meta_d;
    logic ext_sync_q, ext_sync_d;
    logic ext_prev_q, ext_prev_d;
    logic ext_stb_q, ext_stb_d;

    logic                 soft_rst;
    logic                 wr_start;
    logic                 wr_stop;
    logic                 blk_hit;
    logic [2:0]           ch_idx;
    logic [3:0]           off;

    assign soft_rst = BUS_WR && (BUS_ADD == A_CTRL);
    assign wr_start = BUS_WR && (BUS_ADD == A_START);
    assign wr_stop  = BUS_WR && (BUS_ADD == A_STOP);
    assign blk_hit  = (BUS_ADD >= BLK_BASE) && (BUS_ADD < BLK_END);
    assign ch_idx   = 3'((BUS_ADD - BLK_BASE) >> 4);
    assign off      = BUS_ADD[3:0];

    // EXT_START: two-stage synchroniser, then a registered rising-edge strobe
    always_comb begin
        ext_meta_d = EXT_START;
        ext_sync_d = ext_meta_q;
        ext_prev_d = ext_sync_q;
        ext_stb_d  = ext_sync_q && !ext_prev_q;
    end

    always_comb begin
        ext_en_d = ext_en_q;
        chain_d  = chain_q;
        inv_d    = inv_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            delay_d[ch] = delay_q[ch];
            width_d[ch] = width_q[ch];
            rpt_d[ch]   = rpt_q[ch];
        end
        if (soft_rst) begin
            ext_en_d = '0;
            chain_d  = '0;
            inv_d    = '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                delay_d[ch] = '0;
                width_d[ch] = '0;
                rpt_d[ch]   = CNT_WIDTH'(1);
            end
        end else if (BUS_WR) begin
            if (BUS_ADD == A_EXT_EN) ext_en_d = BUS_DATA_IN[CHANNELS-1:0];
            // Channel 0 has no predecessor, so its chain bit is forced to 0
            if (BUS_ADD == A_CHAIN)  chain_d  = BUS_DATA_IN[CHANNELS-1:0] & ~CHANNELS'(1);
            if (BUS_ADD == A_INV)    inv_d    = BUS_DATA_IN[CHANNELS-1:0];
            if (blk_hit) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (ch_idx == 3'(ch)) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (off == 4'(b))     delay_d[ch][8*b +: 8] = BUS_DATA_IN;
                            if (off == 4'(4 + b)) width_d[ch][8*b +: 8] = BUS_DATA_IN;
                            if (off == 4'(8 + b)) rpt_d[ch][8*b +: 8]   = BUS_DATA_IN;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            per_w[ch]  = {1'b0, delay_q[ch]} + {1'b0, width_q[ch]};
            done_w[ch] = (cnt_q[ch] == '0);
        end
    end

    // Channel sequencing; carry ripples FINISH[ch-1] into channel ch's chained start
    always_comb begin
        logic carry;
        logic stop_c;
        logic start_c;
        logic run_c;
        logic fin_c;
        carry   = 1'b0;
        stop_c  = 1'b0;
        start_c = 1'b0;
        run_c   = 1'b0;
        fin_c   = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch]   = cnt_q[ch];
            rep_d[ch]   = rep_q[ch];
            fin_c       = 1'b0;
            stop_c      = wr_stop && BUS_DATA_IN[ch];
            start_c     = ((wr_start && BUS_DATA_IN[ch]) ||
                           (ext_stb_q && ext_en_q[ch]) ||
                           (chain_q[ch] && carry)) && (per_w[ch] != '0);
            run_c       = (cnt_q[ch] != '0);
            pulse_d[ch] = inv_q[ch] ^ ((cnt_q[ch] > {1'b0, delay_q[ch]}) &&
                                       (cnt_q[ch] <= per_w[ch]));
            if (soft_rst) begin
                cnt_d[ch]   = '0;
                rep_d[ch]   = '0;
                pulse_d[ch] = 1'b0;
            end else if (stop_c) begin
                cnt_d[ch] = '0;
            end else if (start_c) begin
                cnt_d[ch] = PW'(1);
                rep_d[ch] = rpt_q[ch];
            end else if (run_c && (cnt_q[ch] >= per_w[ch])) begin
                if (rpt_q[ch] == '0) begin
                    cnt_d[ch] = PW'(1);
                end else if (rep_q[ch] > CNT_WIDTH'(1)) begin
                    rep_d[ch] = rep_q[ch] - CNT_WIDTH'(1);
                    cnt_d[ch] = PW'(1);
                end else begin
                    cnt_d[ch] = '0;
                    rep_d[ch] = '0;
                    fin_c     = 1'b1;
                end
            end else if (run_c) begin
                cnt_d[ch] = cnt_q[ch] + PW'(1);
            end
            fin_w[ch] = fin_c;
            carry     = fin_c;
        end
    end

    always_comb begin
        rd_val = 8'h00;
        if (BUS_ADD == A_CTRL)        rd_val = VERSION;
        else if (BUS_ADD == A_START)  rd_val = 8'(done_w);
        else if (BUS_ADD == A_EXT_EN) rd_val = 8'(ext_en_q);
        else if (BUS_ADD == A_CHAIN)  rd_val = 8'(chain_q);
        else if (BUS_ADD == A_INV)    rd_val = 8'(inv_q);
        else if (blk_hit) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (ch_idx == 3'(ch)) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (off == 4'(b))     rd_val = delay_q[ch][8*b +: 8];
                        if (off == 4'(4 + b)) rd_val = width_q[ch][8*b +: 8];
                        if (off == 4'(8 + b)) rd_val = rpt_q[ch][8*b +: 8];
                    end
                end
            end
        end
        rdata_d = BUS_RD ? rd_val : rdata_q;
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
            ext_prev_q <= 1'b0;
            ext_stb_q  <= 1'b0;
            ext_en_q   <= '0;
            chain_q    <= '0;
            inv_q      <= '0;
            pulse_q    <= '0;
            rdata_q    <= 8'h00;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                delay_q[ch] <= '0;
                width_q[ch] <= '0;
                rpt_q[ch]   <= CNT_WIDTH'(1);
                cnt_q[ch]   <= '0;
                rep_q[ch]   <= '0;
            end
        end else begin
            ext_meta_q <= ext_meta_d;
            ext_sync_q <= ext_sync_d;
            ext_prev_q <= ext_prev_d;
            ext_stb_q  <= ext_stb_d;
            ext_en_q   <= ext_en_d;
            chain_q    <= chain_d;
            inv_q      <= inv_d;
            pulse_q    <= pulse_d;
            rdata_q    <= rdata_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                delay_q[ch] <= delay_d[ch];
                width_q[ch] <= width_d[ch];
                rpt_q[ch]   <= rpt_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                rep_q[ch]   <= rep_d[ch];
            end
        end
    end

    assign PULSE        = pulse_q;
    assign FINISH       = fin_w;
    assign BUS_DATA_OUT = rdata_q;

endmodule

// File: tb/tb_pulse_gen_multi_core.sv
// Bench for pulse_gen_multi_core: register table, hand-written timing sequences,
// and randomised single-channel runs against an arithmetic reference model.
module tb_pulse_gen_multi_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_add = '0;
    logic [7:0]  bus_din = '0;
    logic [7:0]  bus_dout, bus_dout8;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic        ext_start = 1'b0;
    logic [3:0]  pulse, finish;
    logic [1:0]  pulse8, finish8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_gen_multi_core #(.ABUSWIDTH(16), .CHANNELS(4), .CNT_WIDTH(32)) dut (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_din),
        .BUS_DATA_OUT(bus_dout), .BUS_RD(bus_rd), .BUS_WR(bus_wr),
        .EXT_START(ext_start), .PULSE(pulse), .FINISH(finish)
    );

    pulse_gen_multi_core #(.ABUSWIDTH(16), .CHANNELS(2), .CNT_WIDTH(8)) dut8 (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_din),
        .BUS_DATA_OUT(bus_dout8), .BUS_RD(bus_rd), .BUS_WR(bus_wr),
        .EXT_START(ext_start), .PULSE(pulse8), .FINISH(finish8)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_add = a;
        bus_din = d;
        bus_wr  = 1'b1;
        tick();
        bus_wr  = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic [7:0] d8);
        bus_add = a;
        bus_rd  = 1'b1;
        tick();
        bus_rd  = 1'b0;
        d  = bus_dout;
        d8 = bus_dout8;
    endtask

    initial begin
        logic [7:0] rd, rd8;
        logic [3:0] exp_p, exp_f;
        int ch, d, w, r, p, inv;
        logic act;

        vecs[0]  = '{wr:1'b0, addr:16'd0,  wdata:8'h00, exp:8'h02};
        vecs[1]  = '{wr:1'b1, addr:16'd3,  wdata:8'hFF, exp:8'h0F};
        vecs[2]  = '{wr:1'b1, addr:16'd4,  wdata:8'hFF, exp:8'h0E};
        vecs[3]  = '{wr:1'b1, addr:16'd5,  wdata:8'hA5, exp:8'h05};
        vecs[4]  = '{wr:1'b1, addr:16'd16, wdata:8'h12, exp:8'h12};
        vecs[5]  = '{wr:1'b1, addr:16'd19, wdata:8'h9A, exp:8'h9A};
        vecs[6]  = '{wr:1'b1, addr:16'd24, wdata:8'h07, exp:8'h07};
        vecs[7]  = '{wr:1'b1, addr:16'd28, wdata:8'h55, exp:8'h00};
        vecs[8]  = '{wr:1'b1, addr:16'd2,  wdata:8'hFF, exp:8'h00};
        vecs[9]  = '{wr:1'b1, addr:16'd6,  wdata:8'h33, exp:8'h00};
        vecs[10] = '{wr:1'b1, addr:16'd80, wdata:8'h44, exp:8'h00};
        vecs[11] = '{wr:1'b1, addr:16'd69, wdata:8'hC3, exp:8'hC3};
        vecs[12] = '{wr:1'b0, addr:16'd1,  wdata:8'h00, exp:8'h0F};
        vecs[13] = '{wr:1'b1, addr:16'd15, wdata:8'h77, exp:8'h00};

        // Power-on reset
        tick(); tick();
        chk("reset_pulse", 32'(pulse), 32'h0);
        chk("reset_finish", 32'(finish), 32'h0);
        chk("reset_dout", 32'(bus_dout), 32'h0);
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a ch0 run
        bus_write(16'd16, 8'd2);
        bus_write(16'd20, 8'd10);
        bus_read(16'd0, rd, rd8);
        chk("version", 32'(rd), 32'h02);
        bus_write(16'd1, 8'h01);
        tick(); tick(); tick(); tick();
        chk("midrun_pulse_high", 32'(pulse), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pulse", 32'(pulse), 32'h0);
        chk("async_rst_finish", 32'(finish), 32'h0);
        chk("async_rst_dout", 32'(bus_dout), 32'h0);
        tick();
        rst_n = 1'b1;
        bus_read(16'd1, rd, rd8);
        chk("rst_done_mask", 32'(rd), 32'h0F);
        bus_read(16'd24, rd, rd8);
        chk("rst_repeat", 32'(rd), 32'h01);
        bus_read(16'd16, rd, rd8);
        chk("rst_delay", 32'(rd), 32'h00);

        // Register map table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd, rd8);
            chk($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), 32'(rd), 32'(vecs[i].exp));
        end

        // Soft reset keeps BUS_DATA_OUT, clears config
        bus_read(16'd5, rd, rd8);
        bus_write(16'd0, 8'h00);
        chk("soft_rst_keeps_dout", 32'(bus_dout), 32'h05);
        tick();
        chk("soft_rst_pulse", 32'(pulse), 32'h0);
        bus_read(16'd3, rd, rd8);
        chk("soft_rst_ext_en", 32'(rd), 32'h00);
        bus_read(16'd24, rd, rd8);
        chk("soft_rst_repeat", 32'(rd), 32'h01);

        // ch1 D=3 W=2 R=3
        bus_write(16'd32, 8'd3);
        bus_write(16'd36, 8'd2);
        bus_write(16'd40, 8'd3);
        bus_write(16'd1, 8'h02);
        for (int c = 1; c <= 18; c++) begin
            act = (c == 5 || c == 6 || c == 10 || c == 11 || c == 15 || c == 16);
            chk($sformatf("basic_pulse_c%0d", c), 32'(pulse), act ? 32'h2 : 32'h0);
            chk($sformatf("basic_finish_c%0d", c), 32'(finish), (c == 15) ? 32'h2 : 32'h0);
            tick();
        end
        bus_read(16'd1, rd, rd8);
        chk("basic_done", 32'(rd), 32'h0F);

        // External trigger into ch0, ch0 chained into ch1
        bus_write(16'd0, 8'h00);
        bus_write(16'd3, 8'h01);
        bus_write(16'd4, 8'h02);
        bus_write(16'd20, 8'd1);
        bus_write(16'd32, 8'd1);
        bus_write(16'd36, 8'd1);
        ext_start = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            exp_p = (j == 5) ? 4'h1 : (j == 7) ? 4'h2 : 4'h0;
            exp_f = (j == 4) ? 4'h1 : (j == 6) ? 4'h2 : 4'h0;
            chk($sformatf("ext_chain_pulse_j%0d", j), 32'(pulse), 32'(exp_p));
            chk($sformatf("ext_chain_finish_j%0d", j), 32'(finish), 32'(exp_f));
        end
        ext_start = 1'b0;
        tick(); tick(); tick(); tick();

        // Start with DELAY=WIDTH=0 is ignored
        bus_write(16'd0, 8'h00);
        bus_write(16'd1, 8'h04);
        bus_read(16'd1, rd, rd8);
        chk("p0_done", 32'(rd), 32'h0F);
        chk("p0_pulse", 32'(pulse), 32'h0);

        // REPEAT=0 on ch3 with inversion, then stop
        bus_write(16'd64, 8'd1);
        bus_write(16'd68, 8'd1);
        bus_write(16'd72, 8'd0);
        bus_write(16'd5, 8'h08);
        tick();
        chk("inv_idle", 32'(pulse), 32'h8);
        bus_write(16'd1, 8'h08);
        for (int c = 1; c <= 10; c++) begin
            act = (c >= 3) && (c % 2 == 1);
            chk($sformatf("loop_pulse_c%0d", c), 32'(pulse), act ? 32'h0 : 32'h8);
            chk($sformatf("loop_finish_c%0d", c), 32'(finish), 32'h0);
            tick();
        end
        bus_read(16'd1, rd, rd8);
        chk("loop_running", 32'(rd), 32'h07);
        bus_write(16'd2, 8'h08);
        tick(); tick();
        chk("loop_stopped_pulse", 32'(pulse), 32'h8);
        bus_read(16'd1, rd, rd8);
        chk("loop_stopped_done", 32'(rd), 32'h0F);

        // Stop and ext strobe hit ch0 on the same edge
        bus_write(16'd0, 8'h00);
        bus_write(16'd16, 8'd2);
        bus_write(16'd20, 8'd2);
        bus_write(16'd3, 8'h01);
        ext_start = 1'b1;
        tick(); tick(); tick();
        bus_write(16'd2, 8'h01);
        bus_read(16'd1, rd, rd8);
        chk("stop_vs_ext_done", 32'(rd), 32'h0F);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stop_vs_ext_pulse%0d", c), 32'(pulse), 32'h0);
            tick();
        end
        ext_start = 1'b0;
        tick(); tick(); tick(); tick();

        // Randomised single-channel runs against the arithmetic model
        for (int t = 0; t < 8; t++) begin
            bus_write(16'd0, 8'h00);
            ch  = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 5));
            w   = int'($urandom_range(0, 5));
            if (d + w == 0) w = 1;
            r   = int'($urandom_range(1, 3));
            inv = int'($urandom_range(0, 1));
            p   = d + w;
            bus_write(16'(16 + 16 * ch), 8'(d));
            bus_write(16'(20 + 16 * ch), 8'(w));
            bus_write(16'(24 + 16 * ch), 8'(r));
            bus_write(16'd5, 8'(inv << ch));
            tick();
            chk($sformatf("rnd%0d_idle", t), 32'(pulse), 32'(inv << ch));
            bus_write(16'd1, 8'(1 << ch));
            for (int c = 1; c <= r * p + 3; c++) begin
                act   = (c - 1 >= 1) && (c - 1 <= r * p) && (((c - 2) % p) + 1 > d);
                exp_p = 4'(inv << ch) ^ (act ? 4'(1 << ch) : 4'h0);
                exp_f = (c == r * p) ? 4'(1 << ch) : 4'h0;
                chk($sformatf("rnd%0d_ch%0d_d%0d_w%0d_r%0d_pulse_c%0d", t, ch, d, w, r, c),
                    32'(pulse), 32'(exp_p));
                chk($sformatf("rnd%0d_ch%0d_finish_c%0d", t, ch, c), 32'(finish), 32'(exp_f));
                tick();
            end
        end

        // 8-bit counters: DELAY=WIDTH=255 gives a 510-cycle period, inverted output
        bus_write(16'd0, 8'h00);
        bus_write(16'd16, 8'hFF);
        bus_write(16'd20, 8'hFF);
        bus_write(16'd17, 8'h11);
        bus_read(16'd17, rd, rd8);
        chk("w8_upper_byte", 32'(rd8), 32'h00);
        chk("w32_byte1", 32'(rd), 32'h11);
        bus_write(16'd5, 8'h01);
        tick();
        chk("w8_inv_idle", 32'(pulse8), 32'h1);
        bus_read(16'd0, rd, rd8);
        chk("w8_version", 32'(rd8), 32'h02);
        bus_write(16'd1, 8'h01);
        for (int c = 1; c <= 515; c++) begin
            if (c == 1 || c == 256 || c == 257 || c == 511 || c == 512) begin
                act = (c >= 257) && (c <= 511);
                chk($sformatf("w8_pulse_c%0d", c), 32'(pulse8[0]), act ? 32'h0 : 32'h1);
            end
            if (c == 509 || c == 510 || c == 511)
                chk($sformatf("w8_finish_c%0d", c), 32'(finish8), (c == 510) ? 32'h1 : 32'h0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
